msg_scheduler: RTL

- Round-robin arbiter and sequencer that shares one ASCII message transmitter (ROM + character counter + UART TX path) among several game-logic requesters, e.g. "too high", "too low", "correct", "new round".
- Latches each request together with its 4-bit message index.
- Grants one requester at a time, pulses the transmitter's start, waits for its done, then acknowledges the requester.
- A watchdog recovers if done never arrives.

---
 rtl/msg_scheduler.sv | 103 ++++++++++
 1 files changed

// File: rtl/msg_scheduler.sv
// msg_scheduler: round-robin arbiter that shares one message transmitter among requesters, with a done watchdog
module msg_scheduler #(
    parameter int N_REQ   = 4,
    parameter int IDX_W   = 4,
    parameter int TIMEOUT = 2_000_000,
    parameter int TW      = $clog2(TIMEOUT + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*IDX_W-1:0] req_idx,
    output logic [IDX_W-1:0]       msg_index,
    output logic                   start,
    input  logic                   done,
    output logic [N_REQ-1:0]       ack,
    output logic                   busy,
    output logic [N_REQ-1:0]       pending,
    output logic                   timeout_err
);
    localparam int PW = $clog2(N_REQ);

    typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

    state_t           state_q, state_d;
    logic [N_REQ-1:0] pending_q, pending_d, ack_q, ack_d, clr, take, rot;
    logic [IDX_W-1:0] idx_q [N_REQ];
    logic [IDX_W-1:0] idx_d [N_REQ];
    logic [IDX_W-1:0] msg_index_q, msg_index_d;
    logic [PW-1:0]    rr_ptr_q, rr_ptr_d, grant_q, grant_d, off, pick;
    logic [PW:0]      sum;
    logic [TW-1:0]    timer_q, timer_d;
    logic             start_q, start_d, terr_q, terr_d;
    logic             found, hit_limit, finish;

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Rotate pending so bit 0 is rr_ptr; the lowest set bit is the next grant.
    always_comb begin
        rot = N_REQ'({pending_q, pending_q} >> rr_ptr_q);
        off = '0;
        for (int k = N_REQ - 1; k >= 0; k--) if (rot[k]) off = PW'(k);
        sum       = {1'b0, rr_ptr_q} + {1'b0, off};
        pick      = (sum >= (PW+1)'(N_REQ)) ? PW'(sum - (PW+1)'(N_REQ)) : PW'(sum);
        found     = |pending_q;
        hit_limit = timer_q == TW'(TIMEOUT - 1);
        finish    = (state_q == WAIT) && (done || hit_limit);
        state_d   = (state_q == IDLE)  ? (found ? START : IDLE) :
                    (state_q == START) ? WAIT :
                    (state_q == WAIT)  ? (finish ? DONE : WAIT) : IDLE;
    end

    // A request arriving in the ack cycle of its own requester re-queues it.
    always_comb begin
        clr       = (state_q == DONE) ? N_REQ'(1) << grant_q : '0;
        take      = req & (~pending_q | clr);
        pending_d = (pending_q & ~clr) | take;
        for (int i = 0; i < N_REQ; i++) idx_d[i] = take[i] ? req_idx[i*IDX_W +: IDX_W] : idx_q[i];
        grant_d     = (state_q == IDLE && found) ? pick : grant_q;
        msg_index_d = (state_q == IDLE && found) ? idx_q[pick] : msg_index_q;
        rr_ptr_d    = (state_q != DONE) ? rr_ptr_q :
                      (grant_q == PW'(N_REQ - 1)) ? '0 : grant_q + PW'(1);
        start_d     = (state_q == IDLE) && found;
        ack_d       = finish ? N_REQ'(1) << grant_q : '0;
        terr_d      = finish && !done;
        timer_d     = (state_q == IDLE) ? '0 : timer_q + TW'(timer_q != TW'(TIMEOUT));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q   <= '0;
            idx_q       <= '{default: '0};
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            msg_index_q <= '0;
            start_q     <= 1'b0;
            ack_q       <= '0;
            terr_q      <= 1'b0;
            timer_q     <= '0;
        end else begin
            pending_q   <= pending_d;
            idx_q       <= idx_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_q     <= grant_d;
            msg_index_q <= msg_index_d;
            start_q     <= start_d;
            ack_q       <= ack_d;
            terr_q      <= terr_d;
            timer_q     <= timer_d;
        end
    end

    always_comb begin
        busy        = state_q != IDLE;
        start       = start_q;
        ack         = ack_q;
        timeout_err = terr_q;
        msg_index   = msg_index_q;
        pending     = pending_q;
    end
endmodule
